// File: rtl/mmio_gpio_responder_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gpio_pkg : register offsets and default widths for the MMIO GPIO responder
// Revision 1.0
// -----------------------------------------------------------------------------
package gpio_pkg;

  localparam int GPIO_LED_WIDTH = 27;
  localparam int GPIO_SW_WIDTH  = 18;

  localparam logic [1:0] OFF_LED       = 2'd0;
  localparam logic [1:0] OFF_SW_STATUS = 2'd1;
  localparam logic [1:0] OFF_SW_EVENT  = 2'd2;
  localparam logic [1:0] OFF_RESERVED  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mmio_gpio_responder_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mmio_gpio_responder_if : MEM-stage data-port bundle (LDUR/STUR path)
// Revision 1.0
// -----------------------------------------------------------------------------
interface mmio_gpio_responder_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic [DATA_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  hit;

  modport master (
    output address, write_data, mem_write, mem_read,
    input  read_data, hit
  );

  modport slave (
    input  address, write_data, mem_write, mem_read,
    output read_data, hit
  );

endinterface
`default_nettype wire

// File: rtl/mmio_gpio_responder_switch_debouncer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// switch_debouncer : 3-flop synchroniser plus one shared debounce counter
// Revision 1.0
// -----------------------------------------------------------------------------
module switch_debouncer
  import gpio_pkg::*;
#(
  parameter int SW_WIDTH        = GPIO_SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] stable,
  output logic [SW_WIDTH-1:0] new_events
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  r_sync1;
  logic [SW_WIDTH-1:0]  r_sync2;
  logic [SW_WIDTH-1:0]  r_sync2_d;
  logic [SW_WIDTH-1:0]  r_stable;
  logic [CNT_WIDTH-1:0] r_counter;
  logic                 w_settled;
  logic                 w_accept;

  // The counter only advances while the whole bus is steady and differs from stable.
  assign w_settled = (r_sync2 != r_stable) && (r_sync2 == r_sync2_d);
  assign w_accept  = w_settled && (r_counter == c_cnt_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync2_d <= '0;
      r_stable  <= '0;
      r_counter <= '0;
    end else begin
      r_sync1   <= switches;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      if (!w_settled) begin
        r_counter <= '0;
      end else if (w_accept) begin
        r_stable  <= r_sync2;
        r_counter <= '0;
      end else begin
        r_counter <= r_counter + CNT_WIDTH'(1);
      end
    end
  end

  assign stable     = r_stable;
  assign new_events = w_accept ? (r_stable ^ r_sync2) : '0;

endmodule
`default_nettype wire

// File: rtl/mmio_gpio_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mmio_gpio_responder : MMIO GPIO slave - LED register, debounced switches, W1C events
// Revision 1.0
// -----------------------------------------------------------------------------
module mmio_gpio_responder
  import gpio_pkg::*;
#(
  parameter int                  DATA_WIDTH      = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR     = 256,
  parameter int                  DEBOUNCE_CYCLES = 4,
  parameter int                  SW_WIDTH        = GPIO_SW_WIDTH,
  parameter int                  LED_WIDTH       = GPIO_LED_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  mmio_gpio_responder_if.slave  bus,
  input  logic [SW_WIDTH-1:0]   switches,
  output logic [LED_WIDTH-1:0]  leds
);

  logic [DATA_WIDTH-1:0] w_offset_full;
  logic [1:0]            w_offset;
  logic                  w_hit;
  logic                  w_wr;
  logic [SW_WIDTH-1:0]   w_stable;
  logic [SW_WIDTH-1:0]   w_new_events;
  logic [SW_WIDTH-1:0]   w_clear;
  logic [DATA_WIDTH-1:0] w_reg_data;
  logic                  w_unused_wdata;

  logic [LED_WIDTH-1:0]  r_leds;
  logic [SW_WIDTH-1:0]   r_event;

  // Addresses below the base wrap to a huge offset, so one compare covers both edges.
  assign w_offset_full  = bus.address - BASE_ADDR;
  assign w_hit          = (w_offset_full[DATA_WIDTH-1:2] == '0);
  assign w_offset       = w_offset_full[1:0];
  assign w_wr           = bus.mem_write && w_hit;
  assign w_unused_wdata = ^bus.write_data;

  switch_debouncer #(
    .SW_WIDTH        (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock      (clock),
    .reset      (reset),
    .switches   (switches),
    .stable     (w_stable),
    .new_events (w_new_events)
  );

  assign w_clear = (w_wr && (w_offset == OFF_SW_EVENT)) ? bus.write_data[SW_WIDTH-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_leds  <= '0;
      r_event <= '0;
    end else begin
      if (w_wr && (w_offset == OFF_LED)) begin
        r_leds <= bus.write_data[LED_WIDTH-1:0];
      end
      // A same-edge set beats the clear.
      r_event <= (r_event & ~w_clear) | w_new_events;
    end
  end

  always_comb begin
    w_reg_data = '0;
    case (w_offset)
      OFF_LED:       w_reg_data = DATA_WIDTH'(r_leds);
      OFF_SW_STATUS: w_reg_data = DATA_WIDTH'(w_stable);
      OFF_SW_EVENT:  w_reg_data = DATA_WIDTH'(r_event);
      default:       w_reg_data = '0;
    endcase
  end

  assign bus.read_data = (bus.mem_read && w_hit) ? w_reg_data : '0;
  assign bus.hit       = w_hit;
  assign leds          = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_mmio_gpio_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mmio_gpio_responder : directed bench with a windowed behavioural model
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_mmio_gpio_responder;

  localparam logic [63:0] BASE = 64'd256;
  localparam int          DC   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] switches;
  logic [26:0] leds;

  int vectors     = 0;
  int miscompares = 0;

  mmio_gpio_responder_if #(.DATA_WIDTH(64)) bus ();

  mmio_gpio_responder #(
    .DATA_WIDTH      (64),
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (DC),
    .SW_WIDTH        (18),
    .LED_WIDTH       (27)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a change is accepted once DC+1 consecutive synchronised samples agree
  // and differ from the debounced value; sample k reaches the last sync stage two edges later.
  logic [26:0] m_leds;
  logic [17:0] m_stable;
  logic [17:0] m_event;
  logic [17:0] hist[$];
  bit          m_valid = 0;
  logic [17:0] m_v, m_newev, m_clr;
  logic [63:0] m_off;
  bit          m_same;

  function automatic logic [63:0] model_read(input logic [63:0] addr, input logic rd);
    logic [63:0] off;
    off = addr - BASE;
    if (!rd || addr < BASE || addr > BASE + 64'd3) return 64'd0;
    case (off)
      64'd0:   return {37'd0, m_leds};
      64'd1:   return {46'd0, m_stable};
      64'd2:   return {46'd0, m_event};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_leds = '0; m_stable = '0; m_event = '0;
      hist.delete();
      repeat (DC + 3) hist.push_back(18'd0);
      m_valid = 1;
    end else if (m_valid) begin
      m_newev = '0;
      m_v     = hist[hist.size() - 2];
      m_same  = 1;
      for (int k = 0; k <= DC; k++) if (hist[hist.size() - 2 - k] != m_v) m_same = 0;
      if (m_same && m_v != m_stable) begin
        m_newev  = m_stable ^ m_v;
        m_stable = m_v;
      end
      m_clr = '0;
      m_off = bus.address - BASE;
      if (bus.mem_write && bus.address >= BASE && bus.address <= BASE + 64'd3) begin
        if (m_off == 64'd0) m_leds = bus.write_data[26:0];
        if (m_off == 64'd2) m_clr  = bus.write_data[17:0];
      end
      m_event = (m_event & ~m_clr) | m_newev;
      hist.push_back(switches);
      if (hist.size() > DC + 3) void'(hist.pop_front());
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("leds", {37'd0, leds}, {37'd0, m_leds});
      check("hit", {63'd0, bus.hit},
            {63'd0, (bus.address >= BASE && bus.address <= BASE + 64'd3)});
      check("read_data", bus.read_data, model_read(bus.address, bus.mem_read));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.address = 64'd0; bus.write_data = 64'd0;
    bus.mem_write = 1'b0; bus.mem_read = 1'b0;
  endtask

  task automatic rd(input logic [63:0] addr, input logic [63:0] exp, input string name);
    bus.address = addr; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    #1;
    check(name, bus.read_data, exp);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data);
    bus.address = addr; bus.write_data = data;
    bus.mem_write = 1'b1; bus.mem_read = 1'b0;
    step();
    bus.mem_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    switches = '0;
    reset    = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check("reset leds", {37'd0, leds}, 64'd0);
    check("reset hit", {63'd0, bus.hit}, 64'd0);
    rd(BASE + 64'd1, 64'd0, "reset sw_status");
    rd(BASE + 64'd2, 64'd0, "reset sw_event");
    step();

    // LED write, upper bits dropped
    wr(BASE, 64'hFFFF_FFFF_F555_5555);
    check("led write", {37'd0, leds}, 64'h5555555);
    rd(BASE, 64'h5555555, "led read");
    wr(BASE + 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sw_status write ignored", {37'd0, leds}, 64'h5555555);
    rd(BASE + 64'd1, 64'd0, "sw_status after write");
    idle();

    // Clean switch change: visible after edge 7, not edge 6
    switches = 18'h30;
    repeat (6) step();
    rd(BASE + 64'd1, 64'd0, "status edge6");
    rd(BASE + 64'd2, 64'd0, "event edge6");
    step();
    rd(BASE + 64'd1, 64'h30, "status edge7");
    rd(BASE + 64'd2, 64'h30, "event edge7");
    wr(BASE + 64'd2, 64'h10);
    rd(BASE + 64'd2, 64'h20, "w1c partial");
    idle();

    // Glitch shorter than the debounce window
    switches = 18'h15;
    repeat (2) step();
    switches = 18'h30;
    repeat (10) step();
    rd(BASE + 64'd1, 64'h30, "glitch status");
    rd(BASE + 64'd2, 64'h20, "glitch event");
    check("glitch counter", {62'd0, dut.u_debouncer.r_counter}, 64'd0);
    idle();

    // W1C on bit 5 at the same edge bit 5 change is accepted
    switches = 18'h10;
    repeat (6) step();
    rd(BASE + 64'd1, 64'h30, "pre-accept status");
    bus.address = BASE + 64'd2; bus.write_data = 64'h20;
    bus.mem_write = 1'b1; bus.mem_read = 1'b1;
    #1;
    check("rw same-edge old value", bus.read_data, 64'h20);
    step();
    bus.mem_write = 1'b0;
    rd(BASE + 64'd2, 64'h20, "set beats clear");
    rd(BASE + 64'd1, 64'h10, "status bit5 drop");

    // Simultaneous read/write on LED returns pre-edge value
    bus.address = BASE; bus.write_data = 64'h123;
    bus.mem_write = 1'b1; bus.mem_read = 1'b1;
    #1;
    check("led rw pre-edge", bus.read_data, 64'h5555555);
    step();
    bus.mem_write = 1'b0;
    rd(BASE, 64'h123, "led rw post-edge");

    // Out-of-window accesses on both sides
    bus.address = BASE - 64'd1; bus.write_data = '1;
    bus.mem_write = 1'b1; bus.mem_read = 1'b1;
    #1;
    check("below hit", {63'd0, bus.hit}, 64'd0);
    check("below read", bus.read_data, 64'd0);
    step();
    bus.address = BASE + 64'd4;
    #1;
    check("above hit", {63'd0, bus.hit}, 64'd0);
    check("above read", bus.read_data, 64'd0);
    step();
    bus.mem_write = 1'b0;
    check("led after oow", {37'd0, leds}, 64'h123);
    rd(BASE + 64'd2, 64'h20, "event after oow");
    idle();

    // Reset at debounce count 2 drops the pending change
    switches = 18'h3FFFF;
    repeat (5) step();
    check("count before reset", {62'd0, dut.u_debouncer.r_counter}, 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("leds after reset", {37'd0, leds}, 64'd0);
    rd(BASE + 64'd1, 64'd0, "status after reset");
    repeat (6) step();
    rd(BASE + 64'd1, 64'd0, "status release+6");
    step();
    rd(BASE + 64'd1, 64'h3FFFF, "status release+7");
    rd(BASE + 64'd2, 64'h3FFFF, "event release+7");
    idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_gpio_responder.md
Name: mmio_gpio_responder

Overview:
- Memory-mapped GPIO slave on the MEM-stage data port of PipelinedARMv8. It is the responder end of the LDUR/STUR access path.
- STUR to its window drives the 27-bit leds; LDUR reads debounced 18-bit switches and latched switch-change events.
- Sits beside data_memory. The top level muxes read_data when hit is high.

Parameters:
- BASE_ADDR, 256: word address of register offset 0. Same word-index units as data_memory; must be a multiple of 4.
- DEBOUNCE_CYCLES, 4: stable-input cycles required before a switch change is accepted. Must be ≥ 2.
- DATA_WIDTH, 64: data bus width.
- SW_WIDTH, 18: switch count.
- LED_WIDTH, 27: LED count.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  64  word address from MEM stage (ALU result).
- write_data  in  64  STUR data.
- mem_write  in  1  write strobe.
- mem_read  in  1  read strobe.
- read_data  out  64  register contents. Combinational, zero wait.
- hit  out  1  address is within [BASE_ADDR, BASE_ADDR+3]. Combinational.
- switches  in  18  raw asynchronous board switches.
- leds  out  27  LED register.

Behaviour:
- Register map (offset = address - BASE_ADDR):
  - 0 LED: RW; bits [26:0].
  - 1 SW_STATUS: RO; debounced switches in [17:0].
  - 2 SW_EVENT: W1C; bit i set when debounced switch i changes.
  - 3: reserved; reads 0, writes ignored.
- Reset (synchronous, dominates every other event in the same cycle): all of the following go to 0 — leds, sync1, sync2, sync2_d, stable, counter, event.
- Read path:
  - read_data = mem_read & hit ? zero-extended register : 0.
  - Reads have no side effects.
- Write path:
  - Applies on the rising edge when mem_write & hit.
  - LED: leds <= write_data[26:0]; upper bits ignored.
  - SW_EVENT: event <= (event & ~write_data[17:0]) | new_events.
  - Writes to offset 1 or 3 have no effect.
  - A write outside the window changes nothing, and hit stays 0.
- Simultaneous mem_read and mem_write, same offset: read_data returns the pre-edge value; the new value is visible the next cycle.
- Simultaneous W1C and a new event on the same bit: set wins, bit stays 1.
- Synchroniser: sync1 <= switches, then sync2 <= sync1, then sync2_d <= sync2, each cycle.
- Debounce, evaluated every edge with one counter shared by all 18 bits:
  - If sync2 == stable: counter <= 0.
  - Else if sync2 != sync2_d: counter <= 0 (input still moving).
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2; new_events = stable ^ sync2; counter <= 0.
  - Else: counter <= counter+1.
- Counter width: $clog2(DEBOUNCE_CYCLES).
- Latency:
  - A clean switch change settled before edge 1 appears in SW_STATUS and SW_EVENT after edge DEBOUNCE_CYCLES+3 (edge 7 at the default).
  - Any sync2 change inside the window restarts the count.
  - Multiple bits settling together update in the same cycle.
- A switch toggling back before acceptance produces no event, and stable is unchanged.
- Reset asserted mid-debounce drops the pending change. After release, a still-different input is re-debounced from scratch.
- The LED register holds its value across reads, out-of-window accesses and switch activity.

Decomposition:
- Package gpio_pkg:
  - Offsets: OFF_LED=0, OFF_SW_STATUS=1, OFF_SW_EVENT=2.
  - LED_WIDTH and SW_WIDTH constants.
- Sub-module switch_debouncer (clock, reset, switches in, stable out, new_events out) holds the synchroniser, counter and stable register.
- The top level holds address decode, the LED and event registers, and the read mux.

Test Plan:
1. Reset held 2 cycles, then released → leds=0, hit=0. LDUR at BASE+1 and BASE+2 → read_data=0.
2. STUR write_data=64'hFFFF_FFFF_F555_5555 to BASE+0 → leds=27'h5555555 next cycle. Read BASE+0 → 64'h5555555. Write BASE+1 → no change anywhere.
3. switches 0→18'h30, held → SW_STATUS=18'h30 and SW_EVENT=18'h30 after edge 7, not at edge 6. W1C write 18'h10 → SW_EVENT=18'h20.
4. switches toggle 'h15 for 2 cycles, then back to previous → SW_STATUS and SW_EVENT unchanged, counter returns to 0.
5. W1C write to bit 5 on the same edge a change on bit 5 is accepted → bit 5 remains 1.
6. Address BASE-1 and BASE+4 with read and write → hit=0, read_data=0, no register change. Reset asserted at debounce count 2 → stable unchanged. The change is accepted DEBOUNCE_CYCLES+3 edges after reset release.
